// File: rtl/config_stream_loader.sv
// Serial config receiver: shifts bits in MSB-first and commits a complete load to config_data.
// Latency: commit one edge after the final bit; no backpressure, surplus bits only raise overrun.
// Optional trailing even-parity check: define CONFIG_STREAM_LOADER_PARITY_EN.
module config_stream_loader #(
  parameter int CONFIG_WIDTH = 848,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                    clock,
  input  logic                    sync_reset,
  input  logic                    bitstream,
  input  logic                    bitstream_valid,
  input  logic                    stream_done,
  input  logic                    rearm,
  output logic [CONFIG_WIDTH-1:0] config_data,
  output logic                    config_valid,
  output logic [COUNT_WIDTH-1:0]  bit_count,
  output logic                    overrun,
  output logic                    underrun,
  output logic                    parity_error
);

  typedef enum logic [2:0] {IDLE, SHIFT, COMMIT, DONE, ERROR} state_t;

`ifdef CONFIG_STREAM_LOADER_PARITY_EN
  localparam int TERMINAL_INT = CONFIG_WIDTH + 1;
`else
  localparam int TERMINAL_INT = CONFIG_WIDTH;
`endif
  localparam logic [COUNT_WIDTH-1:0] TERMINAL   = COUNT_WIDTH'(TERMINAL_INT);
  localparam logic [COUNT_WIDTH-1:0] DATA_COUNT = COUNT_WIDTH'(CONFIG_WIDTH);

  state_t                  state_q, state_d;
  logic [CONFIG_WIDTH-1:0] shift_q, shift_d;
  logic [CONFIG_WIDTH-1:0] config_data_q, config_data_d;
  logic                    config_valid_q, config_valid_d;
  logic [COUNT_WIDTH-1:0]  bit_count_q, bit_count_d;
  logic                    overrun_q, overrun_d;
  logic                    underrun_q, underrun_d;
`ifdef CONFIG_STREAM_LOADER_PARITY_EN
  logic                    parity_error_q, parity_error_d;
  logic                    par_acc_q, par_acc_d;
  logic                    par_bit_q, par_bit_d;
`endif

  logic                   take_bit;
  logic                   do_clear;
  logic [COUNT_WIDTH-1:0] bit_inc;

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    config_data_d  = config_data_q;
    config_valid_d = config_valid_q;
    bit_count_d    = bit_count_q;
    overrun_d      = overrun_q;
    underrun_d     = underrun_q;
`ifdef CONFIG_STREAM_LOADER_PARITY_EN
    parity_error_d = parity_error_q;
    par_acc_d      = par_acc_q;
    par_bit_d      = par_bit_q;
`endif
    take_bit = 1'b0;
    do_clear = 1'b0;
    bit_inc  = (&bit_count_q) ? bit_count_q : bit_count_q + COUNT_WIDTH'(1);

    unique case (state_q)
      IDLE: begin
        if (bitstream_valid) begin
          take_bit    = 1'b1;
          bit_count_d = COUNT_WIDTH'(1);
          state_d     = (TERMINAL_INT == 1) ? COMMIT : SHIFT;
        end
      end
      SHIFT: begin
        if (bitstream_valid) begin
          take_bit    = 1'b1;
          bit_count_d = bit_inc;
        end
        if (bitstream_valid && (bit_inc == TERMINAL)) begin
          state_d = COMMIT;
        end else if (stream_done) begin
          underrun_d     = 1'b1;
          config_valid_d = 1'b0;
          state_d        = ERROR;
        end
      end
      COMMIT: begin
        if (bitstream_valid) overrun_d = 1'b1;
`ifdef CONFIG_STREAM_LOADER_PARITY_EN
        if (par_acc_q != par_bit_q) begin
          parity_error_d = 1'b1;
          config_valid_d = 1'b0;
          state_d        = ERROR;
        end else begin
          config_data_d  = shift_q;
          config_valid_d = 1'b1;
          state_d        = DONE;
        end
`else
        config_data_d  = shift_q;
        config_valid_d = 1'b1;
        state_d        = DONE;
`endif
      end
      DONE: begin
        // rearm outranks a coincident bit, so that bit never counts as overrun
        if (rearm) do_clear = 1'b1;
        else if (bitstream_valid) overrun_d = 1'b1;
      end
      ERROR: begin
        if (rearm) do_clear = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Data bits go to the shift register; with parity enabled the trailing bit is kept aside
    if (take_bit) begin
      if (bit_count_q < DATA_COUNT) begin
        shift_d = (shift_q << 1) | CONFIG_WIDTH'(bitstream);
`ifdef CONFIG_STREAM_LOADER_PARITY_EN
        par_acc_d = par_acc_q ^ bitstream;
      end else begin
        par_bit_d = bitstream;
`endif
      end
    end

    if (do_clear) begin
      state_d        = IDLE;
      shift_d        = '0;
      config_valid_d = 1'b0;
      bit_count_d    = '0;
      overrun_d      = 1'b0;
      underrun_d     = 1'b0;
`ifdef CONFIG_STREAM_LOADER_PARITY_EN
      parity_error_d = 1'b0;
      par_acc_d      = 1'b0;
      par_bit_d      = 1'b0;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (sync_reset) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      config_data_q  <= '0;
      config_valid_q <= 1'b0;
      bit_count_q    <= '0;
      overrun_q      <= 1'b0;
      underrun_q     <= 1'b0;
`ifdef CONFIG_STREAM_LOADER_PARITY_EN
      parity_error_q <= 1'b0;
      par_acc_q      <= 1'b0;
      par_bit_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      config_data_q  <= config_data_d;
      config_valid_q <= config_valid_d;
      bit_count_q    <= bit_count_d;
      overrun_q      <= overrun_d;
      underrun_q     <= underrun_d;
`ifdef CONFIG_STREAM_LOADER_PARITY_EN
      parity_error_q <= parity_error_d;
      par_acc_q      <= par_acc_d;
      par_bit_q      <= par_bit_d;
`endif
    end
  end

  assign config_data  = config_data_q;
  assign config_valid = config_valid_q;
  assign bit_count    = bit_count_q;
  assign overrun      = overrun_q;
  assign underrun     = underrun_q;
`ifdef CONFIG_STREAM_LOADER_PARITY_EN
  assign parity_error = parity_error_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_config_stream_loader.sv
// Bench for config_stream_loader at CONFIG_WIDTH=8: directed steps plus random loads vs a word-level model.
module tb_config_stream_loader;
  localparam int N = 8;
`ifdef CONFIG_STREAM_LOADER_PARITY_EN
  localparam int TERM = N + 1;
  localparam bit PAR  = 1'b1;
`else
  localparam int TERM = N;
  localparam bit PAR  = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          sync_reset;
  logic          bitstream;
  logic          bitstream_valid;
  logic          stream_done;
  logic          rearm;
  logic [N-1:0]  config_data;
  logic          config_valid;
  logic [31:0]   bit_count;
  logic          overrun;
  logic          underrun;
  logic          parity_error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] exp_data;
  logic         exp_valid, exp_ovr, exp_udr, exp_perr;
  int           exp_count;

  config_stream_loader #(.CONFIG_WIDTH(N), .COUNT_WIDTH(32)) dut (
    .clock(clock), .sync_reset(sync_reset), .bitstream(bitstream),
    .bitstream_valid(bitstream_valid), .stream_done(stream_done), .rearm(rearm),
    .config_data(config_data), .config_valid(config_valid), .bit_count(bit_count),
    .overrun(overrun), .underrun(underrun), .parity_error(parity_error)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_data"},  64'(config_data),  64'(exp_data));
    chk({tag, "_valid"}, 64'(config_valid), 64'(exp_valid));
    chk({tag, "_count"}, 64'(bit_count),    64'(exp_count));
    chk({tag, "_ovr"},   64'(overrun),      64'(exp_ovr));
    chk({tag, "_udr"},   64'(underrun),     64'(exp_udr));
    chk({tag, "_perr"},  64'(parity_error), 64'(exp_perr));
  endtask

  // Inputs change on the falling edge and outputs are read there too
  task automatic cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send_bit(input logic b);
    bitstream       = b;
    bitstream_valid = 1'b1;
    cycle();
    bitstream_valid = 1'b0;
    bitstream       = 1'($urandom);
  endtask

  // Data bits lo..hi-1 of w, MSB first, from a fresh load; count must hold through each gap
  task automatic send_range(input logic [N-1:0] w, input int lo, input int hi, input int gap);
    for (int i = lo; i < hi; i++) begin
      send_bit(w[N-1-i]);
      if (i != hi - 1) idle(gap);
      chk("count_step", 64'(bit_count), 64'(i + 1));
    end
  endtask

  task automatic send_word(input logic [N-1:0] w, input int gap, input bit bad_par, input bit sd_last);
    if (PAR) begin
      send_range(w, 0, N, gap);
      idle(gap);
      stream_done = sd_last;
      send_bit(logic'((^w) ^ bad_par));
    end else begin
      send_range(w, 0, N - 1, gap);
      idle(gap);
      stream_done = sd_last;
      send_bit(w[0]);
    end
    stream_done = 1'b0;
  endtask

  task automatic commit_expect(input logic [N-1:0] w, input bit bad_par);
    if (PAR && bad_par) begin
      exp_perr  = 1'b1;
      exp_valid = 1'b0;
    end else begin
      exp_data  = w;
      exp_valid = 1'b1;
    end
    exp_count = TERM;
  endtask

  task automatic do_rearm();
    rearm = 1'b1;
    cycle();
    rearm     = 1'b0;
    exp_valid = 1'b0;
    exp_count = 0;
    exp_ovr   = 1'b0;
    exp_udr   = 1'b0;
    exp_perr  = 1'b0;
  endtask

  initial begin
    logic [N-1:0] w;
    int mode, gap, k, extra;
    bit bad, sdl;

    sync_reset = 1'b1; bitstream = 1'b0; bitstream_valid = 1'b0;
    stream_done = 1'b0; rearm = 1'b0;
    idle(2);
    sync_reset = 1'b0;
    exp_data = '0; exp_valid = 1'b0; exp_count = 0;
    exp_ovr = 1'b0; exp_udr = 1'b0; exp_perr = 1'b0;
    check_all("reset");

    // back-to-back load, commit one edge after the final bit
    send_word(8'hB2, 0, 1'b0, 1'b0);
    chk("latency_valid", 64'(config_valid), 64'(0));
    cycle();
    commit_expect(8'hB2, 1'b0);
    check_all("b2_consec");

    do_rearm();
    check_all("rearm_hold");
    send_word(8'hB2, 3, 1'b0, 1'b0);
    cycle();
    commit_expect(8'hB2, 1'b0);
    check_all("b2_gaps");

    send_bit(1'b1);
    send_bit(1'b0);
    exp_ovr = 1'b1;
    check_all("overrun_done");

    // rearm with a coincident bit in DONE
    rearm = 1'b1; bitstream = 1'b1; bitstream_valid = 1'b1;
    cycle();
    rearm = 1'b0; bitstream_valid = 1'b0;
    exp_valid = 1'b0; exp_count = 0; exp_ovr = 1'b0;
    check_all("rearm_vs_bit");

    stream_done = 1'b1;
    idle(2);
    stream_done = 1'b0;
    check_all("done_in_idle");

    // completing bit with stream_done, then a bit during the commit cycle
    send_word(8'h5A, 0, 1'b0, 1'b1);
    send_bit(1'b1);
    commit_expect(8'h5A, 1'b0);
    exp_ovr = 1'b1;
    check_all("commit_overrun");

    do_rearm();
    send_range(8'hE7, 0, 5, 0);
    stream_done = 1'b1;
    cycle();
    stream_done = 1'b0;
    exp_udr = 1'b1; exp_count = 5;
    check_all("underrun");
    send_bit(1'b1);
    check_all("error_ignores");
    do_rearm();
    check_all("rearm_error");
    send_word(8'h3C, 0, 1'b0, 1'b0);
    cycle();
    commit_expect(8'h3C, 1'b0);
    check_all("load_3c");

    // rearm during SHIFT has no effect
    do_rearm();
    send_range(8'hC6, 0, 3, 0);
    rearm = 1'b1;
    cycle();
    rearm = 1'b0;
    chk("rearm_in_shift", 64'(bit_count), 64'(3));
    send_range(8'hC6, 3, N, 0);
    if (PAR) send_bit(logic'(^8'hC6));
    cycle();
    commit_expect(8'hC6, 1'b0);
    check_all("load_c6");

    do_rearm();
    send_range(8'hFF, 0, 4, 0);
    sync_reset = 1'b1;
    cycle();
    sync_reset = 1'b0;
    exp_data = '0; exp_valid = 1'b0; exp_count = 0;
    exp_ovr = 1'b0; exp_udr = 1'b0; exp_perr = 1'b0;
    check_all("reset_midload");
    send_word(8'h81, 0, 1'b0, 1'b0);
    cycle();
    commit_expect(8'h81, 1'b0);
    check_all("load_81");

`ifdef CONFIG_STREAM_LOADER_PARITY_EN
    do_rearm();
    send_word(8'hB2, 0, 1'b1, 1'b0);
    cycle();
    commit_expect(8'hB2, 1'b1);
    check_all("parity_bad");
    do_rearm();
    check_all("parity_clear");
    send_word(8'hB2, 0, 1'b0, 1'b0);
    cycle();
    commit_expect(8'hB2, 1'b0);
    check_all("parity_good");
`endif

    for (int it = 0; it < 24; it++) begin
      do_rearm();
      check_all("rnd_rearm");
      stream_done = 1'($urandom);
      idle($urandom_range(0, 2));
      stream_done = 1'b0;
      w     = N'($urandom);
      gap   = $urandom_range(0, 3);
      mode  = $urandom_range(0, 3);
      bad   = (mode == 3);
      sdl   = 1'($urandom);
      if (mode == 1) begin
        k = $urandom_range(1, TERM - 1);
        send_range(w, 0, k, gap);
        idle(gap);
        stream_done = 1'b1;
        cycle();
        stream_done = 1'b0;
        exp_udr = 1'b1; exp_count = k;
        check_all("rnd_underrun");
      end else begin
        send_word(w, gap, bad, sdl);
        cycle();
        commit_expect(w, bad);
        if (mode == 2) begin
          extra = $urandom_range(1, 3);
          for (int e = 0; e < extra; e++) send_bit(1'($urandom));
          exp_ovr = 1'b1;
        end
        check_all("rnd_load");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/config_stream_loader.md
Name: config_stream_loader

Overview:
- Receive end of the serial configuration bitstream produced by the CGRA configurator.
- Shifts bits in, counts them against the expected length, and commits the full word to a parallel shadow-protected output only when the load is complete and correct.
- Sits between the configurator output and a block's config register (FuncConfig, Mux*Config, ConstVal …), so downstream logic never sees a partially loaded configuration.

Parameters:
- CONFIG_WIDTH, 848, number of configuration data bits expected per load (≥1).
- COUNT_WIDTH, 32, width of the received-bit counter; must hold CONFIG_WIDTH+1.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- sync_reset  in  1  synchronous, active-high reset.
- bitstream  in  1  serial config bit; sampled only when bitstream_valid=1.
- bitstream_valid  in  1  qualifies bitstream; one bit accepted per cycle high.
- stream_done  in  1  level from the upstream configurator: no further bits will come.
- rearm  in  1  single-cycle request to start a new load without reset.
- config_data  out  CONFIG_WIDTH  committed configuration; first received bit at MSB [CONFIG_WIDTH-1].
- config_valid  out  1  high while config_data holds a complete committed load.
- bit_count  out  COUNT_WIDTH  bits accepted in the current load.
- overrun  out  1  sticky: bit received after the load was complete.
- underrun  out  1  sticky: stream_done seen before all bits arrived.
- parity_error  out  1  sticky parity failure (see Optional Feature); constant 0 when the feature is compiled out.

Behaviour:
- Reset, applied on the edge where sync_reset=1 and taking priority over all inputs:
  - state=IDLE; config_data=0; config_valid=0; bit_count=0; overrun, underrun and parity_error=0; internal shift register=0.
- Reset mid-load discards all partial bits. No commit happens.
- Bit order: each accepted bit is shifted in as shift <= {shift[CONFIG_WIDTH-2:0], bitstream}. After N=CONFIG_WIDTH bits, the i-th received bit (0-based) sits at bit [CONFIG_WIDTH-1-i].
- X values on bitstream are don't-care. They are stored as received.
- States:
  - IDLE: bit_count=0. On bitstream_valid=1, accept the bit, bit_count=1, go to SHIFT. If N=1, go directly to COMMIT.
  - SHIFT: on bitstream_valid=1, accept the bit and increment bit_count. When the accepted bit makes bit_count=N (N+1 with the feature), go to COMMIT. If stream_done=1 with no completing bit that cycle, set underrun and go to ERROR.
  - COMMIT: lasts exactly one cycle.
    - config_data <= shift; config_valid <= 1; go to DONE.
    - bitstream_valid=1 in this cycle sets overrun. The bit is ignored.
  - DONE: holds config_data and config_valid. bitstream_valid=1 sets overrun and the bit is ignored; config_valid stays 1.
  - ERROR: config_valid=0; the previous config_data is held. Further bits are ignored.
- Latency: when the final bit is sampled at edge k, config_data and config_valid update at edge k+1.
- rearm: honoured in DONE or ERROR only; ignored in IDLE, SHIFT and COMMIT.
  - Effect: go to IDLE, bit_count=0, config_valid=0, clear overrun, underrun and parity_error, clear the shift register.
  - config_data keeps its last committed value until the next commit.
- Simultaneous events:
  - rearm together with bitstream_valid in DONE: rearm wins and the bit is discarded (no overrun set).
  - stream_done in IDLE: no effect, so a zero-length stream is not an error.
  - stream_done in the same cycle as the completing bit: the commit proceeds normally.
- bit_count saturates at its terminal value and never wraps.

Optional Feature:
- Macro: CONFIG_STREAM_LOADER_PARITY_EN.
- With the macro defined:
  - The stream carries CONFIG_WIDTH data bits followed by one trailing even-parity bit, equal to the XOR of all data bits.
  - The terminal count is CONFIG_WIDTH+1. The parity bit is not stored in config_data.
  - In COMMIT, a mismatch sets parity_error, leaves config_data unchanged and goes to ERROR instead of DONE.
- Without the macro: the terminal count is CONFIG_WIDTH, parity_error is tied to 0, and no check is made.

Test Plan:
- CONFIG_WIDTH=8, reset, send bits 1,0,1,1,0,0,1,0 on consecutive cycles → one edge after the last bit, config_data=8'hB2, config_valid=1, bit_count=8.
- Same stream with bitstream_valid gaps of 3 idle cycles between bits → identical result; bit_count holds its value during the gaps.
- After the commit, send 2 extra bits → overrun=1, config_data stays 8'hB2, config_valid stays 1.
- Send 5 bits then assert stream_done → underrun=1, config_valid=0; then pulse rearm and send 8'h3C → config_data=8'h3C, config_valid=1, underrun=0.
- Assert sync_reset after 4 bits, then send a full 8'h81 → config_data=8'h81; no trace of the partial load.
- With CONFIG_STREAM_LOADER_PARITY_EN: 8'hB2 followed by parity 0 → commits 8'hB2. The same data with parity 1 → parity_error=1, config_valid=0, config_data unchanged.
